// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   localparam int DEF_LENGTH = 32;

   // Divide-by-zero quotient is every bit set; replicated to LENGTH at the use site.
   localparam logic DBZ_QUOT_FILL = 1'b1;

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: operand and result valid/ready handshakes of the divider.
interface seq_divider_if
   import div_pkg::*;
#(
   parameter int LENGTH = DEF_LENGTH
);

   logic              in_valid;
   logic              in_ready;
   logic [LENGTH-1:0] dividend;
   logic [LENGTH-1:0] divisor;
   logic              signed_op;
   logic              out_valid;
   logic              out_ready;
   logic [LENGTH-1:0] quotient;
   logic [LENGTH-1:0] remainder;
   logic              div_by_zero;

   modport master (
      output in_valid, dividend, divisor, signed_op, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, signed_op, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational non-restoring division iteration.
module div_step
   import div_pkg::*;
#(
   parameter int LENGTH = DEF_LENGTH
) (
   input  logic signed [LENGTH:0] pr,
   input  logic [LENGTH-1:0]      divisor,
   input  logic                   dbit,
   output logic signed [LENGTH:0] pr_next,
   output logic                   qbit
);

   logic signed [LENGTH:0] shifted;
   logic signed [LENGTH:0] dext;

   // Dropping pr's top bit on the shift is safe: the result is exact modulo 2^(LENGTH+1)
   // and always lands back inside [-divisor, divisor).
   always_comb begin
      shifted = {pr[LENGTH-1:0], dbit};
      dext    = {1'b0, divisor};
      pr_next = pr[LENGTH] ? (shifted + dext) : (shifted - dext);
      qbit    = ~pr_next[LENGTH];
   end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative non-restoring divider, one quotient bit per cycle plus a FIX cycle.
// Define DIV_SIGNED_EN to honour signed_op; without it every operation is unsigned.
module seq_divider
   import div_pkg::*;
#(
   parameter int LENGTH = DEF_LENGTH
) (
   input  logic         clk,
   input  logic         rst,
   seq_divider_if.slave io
);

   div_state_e             state, state_nxt;
   logic                   accept;
   logic                   dbz_in;
   logic                   last_step;
   logic signed [LENGTH:0] pr_p0;
   logic signed [LENGTH:0] pr_step;
   logic [LENGTH-1:0]      qr_p0;
   logic [LENGTH-1:0]      dvs_p0;
   logic [LENGTH-1:0]      cnt_p0;
   logic                   qbit;
   logic [LENGTH-1:0]      dvd_mag, dvs_mag;
   logic [LENGTH-1:0]      rem_fix, quot_out, rem_out;
   logic [LENGTH-1:0]      quot_r, rem_r;
   logic                   dbz_r;

   assign dbz_in    = (io.divisor == '0);
   assign last_step = (state == CALC) && (cnt_p0 == LENGTH'(LENGTH - 1));
   assign rem_fix   = pr_p0[LENGTH] ? (pr_p0[LENGTH-1:0] + dvs_p0) : pr_p0[LENGTH-1:0];

`ifdef DIV_SIGNED_EN
   logic dvd_neg, dvs_neg, neg_q_p0, neg_r_p0;

   function automatic logic [LENGTH-1:0] neg_if(input logic [LENGTH-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   assign dvd_neg  = io.signed_op & io.dividend[LENGTH-1];
   assign dvs_neg  = io.signed_op & io.divisor[LENGTH-1];
   assign dvd_mag  = neg_if(io.dividend, dvd_neg);
   assign dvs_mag  = neg_if(io.divisor, dvs_neg);
   assign quot_out = neg_if(qr_p0, neg_q_p0);
   assign rem_out  = neg_if(rem_fix, neg_r_p0);

   always_ff @(posedge clk) begin
      if (accept) begin
         neg_q_p0 <= dvd_neg ^ dvs_neg;
         neg_r_p0 <= dvd_neg;
      end
   end
`else
   logic unused_signed_op;

   assign unused_signed_op = io.signed_op;
   assign dvd_mag          = io.dividend;
   assign dvs_mag          = io.divisor;
   assign quot_out         = qr_p0;
   assign rem_out          = rem_fix;
`endif

   div_step #(.LENGTH(LENGTH)) u_step (
      .pr      (pr_p0),
      .divisor (dvs_p0),
      .dbit    (qr_p0[LENGTH-1]),
      .pr_next (pr_step),
      .qbit    (qbit)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (io.in_valid) begin
               accept    = 1'b1;
               state_nxt = dbz_in ? DONE : CALC;
            end
         end
         CALC:    if (last_step) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    if (io.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Dividend magnitude lives in qr_p0 and shifts out MSB-first as quotient bits shift in.
   always_ff @(posedge clk) begin
      if (accept) begin
         pr_p0  <= '0;
         qr_p0  <= dvd_mag;
         dvs_p0 <= dvs_mag;
         cnt_p0 <= '0;
      end else if (state == CALC) begin
         pr_p0  <= pr_step;
         qr_p0  <= {qr_p0[LENGTH-2:0], qbit};
         cnt_p0 <= cnt_p0 + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quot_r <= '0;
         rem_r  <= '0;
         dbz_r  <= 1'b0;
      end else if (accept) begin
         dbz_r <= dbz_in;
         if (dbz_in) begin
            quot_r <= {LENGTH{DBZ_QUOT_FILL}};
            rem_r  <= io.dividend;
         end
      end else if (state == FIX) begin
         quot_r <= quot_out;
         rem_r  <= rem_out;
      end
   end

   assign io.in_ready    = (state == IDLE) & ~rst;
   assign io.out_valid   = (state == DONE);
   assign io.quotient    = quot_r;
   assign io.remainder   = rem_r;
   assign io.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table, handshake corner sequences and randomized ops vs. a reference model.
module tb_seq_divider;

   localparam int LENGTH = 32;
`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   typedef logic [LENGTH-1:0] word_t;
   typedef struct {
      word_t a;
      word_t b;
      logic  s;
      word_t q;
      word_t r;
      logic  z;
      int    lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   seq_divider_if #(.LENGTH(LENGTH)) dif ();

   seq_divider #(.LENGTH(LENGTH)) dut (
      .clk (clk),
      .rst (rst),
      .io  (dif.slave)
   );

   always #5 clk = ~clk;

   int    n_pass  = 0;
   int    n_total = 0;
   vec_t  vecs[11];

   task automatic check(input string name, input word_t act, input word_t exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Reference: plain integer division, truncating toward zero in the signed case.
   function automatic void model(input word_t a, input word_t b, input logic s,
                                 output word_t q, output word_t r, output logic z);
      longint sa, sb;
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else if (s && SIGNED_EN) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = word_t'(sa / sb);
         r  = word_t'(sa % sb);
         z  = 1'b0;
      end else begin
         q = a / b;
         r = a % b;
         z = 1'b0;
      end
   endfunction

   task automatic issue(input word_t a, input word_t b, input logic s);
      dif.in_valid  = 1'b1;
      dif.dividend  = a;
      dif.divisor   = b;
      dif.signed_op = s;
      @(posedge clk); #1;
      dif.in_valid  = 1'b0;
   endtask

   // Cycle 1 is the cycle right after the accepting edge.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!dif.out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic retire();
      dif.out_ready = 1'b1;
      @(posedge clk); #1;
      dif.out_ready = 1'b0;
      check("out_valid_after_retire", word_t'(dif.out_valid), 0);
      check("in_ready_after_retire", word_t'(dif.in_ready), 1);
   endtask

   task automatic run_op(input word_t a, input word_t b, input logic s,
                         output word_t q, output word_t r, output logic z, output int cyc);
      issue(a, b, s);
      wait_done(cyc);
      q = dif.quotient;
      r = dif.remainder;
      z = dif.div_by_zero;
      retire();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      word_t q, r, eq, er, a, b;
      logic  z, ez, s;
      int    cyc;

      dif.in_valid  = 1'b0;
      dif.dividend  = '0;
      dif.divisor   = '0;
      dif.signed_op = 1'b0;
      dif.out_ready = 1'b0;
      rst           = 1'b1;

      vecs[0]  = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34};
      vecs[1]  = '{32'hFFFF_FFF9, 32'd2, 1'b1,
                   SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC,
                   SIGNED_EN ? 32'hFFFF_FFFF : 32'd1, 1'b0, 34};
      vecs[2]  = '{32'd7, 32'hFFFF_FFFE, 1'b1,
                   SIGNED_EN ? 32'hFFFF_FFFD : 32'd0,
                   SIGNED_EN ? 32'd1 : 32'd7, 1'b0, 34};
      vecs[3]  = '{32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1};
      vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                   SIGNED_EN ? 32'h8000_0000 : 32'd0,
                   SIGNED_EN ? 32'd0 : 32'h8000_0000, 1'b0, 34};
      vecs[5]  = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34};
      vecs[6]  = '{32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 34};
      vecs[7]  = '{32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1,
                   SIGNED_EN ? 32'd2 : 32'd0,
                   SIGNED_EN ? 32'hFFFF_FFFE : 32'hFFFF_FFF8, 1'b0, 34};
      vecs[8]  = '{32'hFFFF_FFFF, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1};
      vecs[9]  = '{32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0, 34};
      vecs[10] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'hFFFF_FFFE, 1'b0, 34};

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", word_t'(dif.in_ready), 0);
      check("rst_out_valid", word_t'(dif.out_valid), 0);
      check("rst_quotient", dif.quotient, 0);
      check("rst_remainder", dif.remainder, 0);
      check("rst_div_by_zero", word_t'(dif.div_by_zero), 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", word_t'(dif.in_ready), 1);

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, q, r, z, cyc);
         check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
         check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
         check($sformatf("vec%0d_div_by_zero", i), word_t'(z), word_t'(vecs[i].z));
         check($sformatf("vec%0d_latency", i), word_t'(cyc), word_t'(vecs[i].lat));
      end

      // Consumer stalls for 5 cycles; a new operand offered meanwhile must be ignored.
      issue(32'd100, 32'd7, 1'b0);
      wait_done(cyc);
      check("stall_latency", word_t'(cyc), 34);
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            dif.in_valid = 1'b1;
            dif.dividend = 32'd50;
            dif.divisor  = 32'd5;
         end
         @(posedge clk); #1;
         check($sformatf("stall%0d_out_valid", k), word_t'(dif.out_valid), 1);
         check($sformatf("stall%0d_in_ready", k), word_t'(dif.in_ready), 0);
         check($sformatf("stall%0d_quotient", k), dif.quotient, 32'd14);
         check($sformatf("stall%0d_remainder", k), dif.remainder, 32'd2);
      end
      dif.in_valid = 1'b0;
      retire();

      // Reset in the middle of CALC, then a fresh division.
      issue(32'd100, 32'd7, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("midcalc_busy_in_ready", word_t'(dif.in_ready), 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_in_ready_held", word_t'(dif.in_ready), 0);
      check("midrst_out_valid", word_t'(dif.out_valid), 0);
      rst = 1'b0;
      #1;
      check("midrst_in_ready", word_t'(dif.in_ready), 1);
      check("midrst_quotient", dif.quotient, 0);
      check("midrst_remainder", dif.remainder, 0);
      run_op(32'd100, 32'd7, 1'b0, q, r, z, cyc);
      check("after_rst_quotient", q, 32'd14);
      check("after_rst_remainder", r, 32'd2);
      check("after_rst_latency", word_t'(cyc), 34);

      for (int n = 0; n < 250; n++) begin
         a = $urandom;
         if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
         case ($urandom_range(0, 4))
            0:       b = word_t'($urandom_range(1, 15));
            1:       b = $urandom;
            2:       b = a >> $urandom_range(0, 31);
            3:       b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'hFFFF_FFFF;
            default: b = word_t'($urandom_range(0, 65535));
         endcase
         s = 1'($urandom_range(0, 1));
         model(a, b, s, eq, er, ez);
         run_op(a, b, s, q, r, z, cyc);
         check($sformatf("rnd%0d_quotient a=%08h b=%08h s=%0d", n, a, b, s), q, eq);
         check($sformatf("rnd%0d_remainder a=%08h b=%08h s=%0d", n, a, b, s), r, er);
         check($sformatf("rnd%0d_div_by_zero", n), word_t'(z), word_t'(ez));
         check($sformatf("rnd%0d_latency", n), word_t'(cyc), (b == '0) ? 32'd1 : 32'd34);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
